axis_combiner: RTL and testbench
================================

AXIS_COMBINER -- requirements
Module: axis_combiner

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of complex input channels (2..16).
REQ-002 The block SHALL have parameter SDATA_WIDTH, default 128, giving the per-stream input tdata width.
REQ-003 The block SHALL have parameter SSAMPLE_WIDTH, default 16, giving the signed input sample width.
REQ-004 The block SHALL have parameter MSAMPLE_WIDTH, default 16, giving the signed output sample width; SAMPLES = SDATA_WIDTH/SSAMPLE_WIDTH and MDATA_WIDTH = SAMPLES*MSAMPLE_WIDTH.
REQ-005 The block SHALL have parameter SHIFT, default 0, giving the arithmetic right shift applied to each sum (0..clog2(NUM_CH)).
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock for all logic.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have ports s_axis_real_tdata / s_axis_imag_tdata, input, NUM_CH*SDATA_WIDTH bits: channel k occupies bits [k*SDATA_WIDTH +: SDATA_WIDTH].
REQ-009 The block SHALL have ports s_axis_real_tvalid / s_axis_imag_tvalid, input, NUM_CH bits: per-channel valid.
REQ-010 The block SHALL have ports s_axis_real_tready / s_axis_imag_tready, output, NUM_CH bits: per-channel ready.
REQ-011 The block SHALL have ports s_axis_real_tlast / s_axis_imag_tlast, input, NUM_CH bits: per-channel frame end.
REQ-012 The block SHALL have ports m_axis_real_tdata / m_axis_imag_tdata, output, MDATA_WIDTH bits: the summed samples.
REQ-013 The block SHALL have ports m_axis_real_tkeep / m_axis_imag_tkeep, output, MDATA_WIDTH/8 bits: all ones while valid.
REQ-014 The block SHALL have ports m_axis_real_tvalid, m_axis_real_tlast, m_axis_imag_tvalid and m_axis_imag_tlast, all outputs, 1 bit each.
REQ-015 The block SHALL have ports m_axis_real_tready / m_axis_imag_tready, input, 1 bit each.
REQ-016 The block SHALL have port tlast_err, output, 1 bit: sticky flag for a tlast misalignment between channels.
REQ-017 The block SHALL have port frame_count, output, 32 bits: number of output frames completed.

Function
REQ-018 The block SHALL accept an input beat only when all 2*NUM_CH tvalid bits are high and the pipeline can advance; it SHALL assert all tready bits in exactly that cycle and never otherwise.
REQ-019 Each output sample i SHALL equal the sign-extended sum over all channels of sample i, shifted right arithmetically by SHIFT, then reduced to MSAMPLE_WIDTH as set by REQ-031/REQ-032.
REQ-020 The sum SHALL be computed at SSAMPLE_WIDTH+clog2(NUM_CH) bits with no intermediate overflow.
REQ-021 The pipeline SHALL have two register stages (sum, output); latency from accepted beat to m_axis tvalid SHALL be 2 cycles when not stalled.
REQ-022 The pipeline SHALL advance when the output register is empty or both m_axis_real_tready and m_axis_imag_tready are high; otherwise every stage SHALL hold its contents unchanged.
REQ-023 The real and imag tvalid outputs SHALL always be equal; a beat completes only when both treadys are high in the same cycle.
REQ-024 Output tlast SHALL be the tlast of channel 0's real stream for the same beat, carried through the pipeline.
REQ-025 If the 2*NUM_CH input tlast bits of an accepted beat are not all equal, tlast_err SHALL be set and SHALL remain set until reset.
REQ-026 frame_count SHALL increment by 1 on each completed output beat with tlast=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 Simultaneous acceptance and output completion SHALL sustain one beat per cycle with no bubble.

Reset
REQ-028 While reset is high, all tready outputs, m tvalid, m tlast and tlast_err SHALL be 0, frame_count SHALL be 0, and tdata/tkeep outputs SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard all in-flight beats; the first accepted beat after reset SHALL be treated as the first beat of a frame.
REQ-030 Reset SHALL take effect asynchronously and be released synchronously to clock.

Configuration
REQ-031 With macro AXIS_COMBINER_SAT_EN defined, each shifted sum outside the signed MSAMPLE_WIDTH range SHALL saturate to the maximum or minimum value.
REQ-032 Without AXIS_COMBINER_SAT_EN, each shifted sum SHALL be truncated to its low MSAMPLE_WIDTH bits (two's-complement wrap).

Verification
REQ-033 NUM_CH=4, SHIFT=0, all samples 0x0100 real and 0xFF00 imag -> real 0x0400 and imag 0xFC00 on every sample, 2 cycles after acceptance.
REQ-034 SAT_EN defined, all samples 0x7000 -> 0x7FFF; without the macro -> 0xC000.
REQ-035 Channel 2 real tvalid held low for 5 cycles, others high -> all tready bits stay 0 for those 5 cycles and no output beat is produced.
REQ-036 m tready low for 3 cycles with 2 beats in flight -> outputs held stable, no input accepted, no beat lost or duplicated after release.
REQ-037 Channel 1 tlast=1 while the other channels have tlast=0 -> tlast_err=1 until reset and frame_count unchanged; a 4-beat frame with aligned tlast -> frame_count increments by 1.
REQ-038 Reset asserted with 2 beats in flight -> m tvalid=0 immediately; after release a fresh frame produces correct sums with tlast_err=0.

Source files
------------

// File: rtl/axis_combiner_if.sv
// Stream bundle for the complex channel combiner.
// Carries the per-channel real/imag AXI-Stream inputs and the summed
// real/imag AXI-Stream outputs. The combiner connects through the
// "slave" modport; whatever feeds it and drains it uses "master".
interface axis_combiner_if #(
    parameter int NUM_CH      = 4,
    parameter int SDATA_WIDTH = 128,
    parameter int MDATA_WIDTH = 128
);
    // Input channels, channel k at [k*SDATA_WIDTH +: SDATA_WIDTH]
    logic [NUM_CH*SDATA_WIDTH-1:0] s_axis_real_tdata;
    logic [NUM_CH*SDATA_WIDTH-1:0] s_axis_imag_tdata;
    logic [NUM_CH-1:0]             s_axis_real_tvalid;
    logic [NUM_CH-1:0]             s_axis_imag_tvalid;
    logic [NUM_CH-1:0]             s_axis_real_tready;
    logic [NUM_CH-1:0]             s_axis_imag_tready;
    logic [NUM_CH-1:0]             s_axis_real_tlast;
    logic [NUM_CH-1:0]             s_axis_imag_tlast;

    // Combined output streams
    logic [MDATA_WIDTH-1:0]        m_axis_real_tdata;
    logic [MDATA_WIDTH-1:0]        m_axis_imag_tdata;
    logic [MDATA_WIDTH/8-1:0]      m_axis_real_tkeep;
    logic [MDATA_WIDTH/8-1:0]      m_axis_imag_tkeep;
    logic                          m_axis_real_tvalid;
    logic                          m_axis_imag_tvalid;
    logic                          m_axis_real_tlast;
    logic                          m_axis_imag_tlast;
    logic                          m_axis_real_tready;
    logic                          m_axis_imag_tready;

    modport slave (
        input  s_axis_real_tdata, s_axis_imag_tdata,
        input  s_axis_real_tvalid, s_axis_imag_tvalid,
        output s_axis_real_tready, s_axis_imag_tready,
        input  s_axis_real_tlast, s_axis_imag_tlast,
        output m_axis_real_tdata, m_axis_imag_tdata,
        output m_axis_real_tkeep, m_axis_imag_tkeep,
        output m_axis_real_tvalid, m_axis_imag_tvalid,
        output m_axis_real_tlast, m_axis_imag_tlast,
        input  m_axis_real_tready, m_axis_imag_tready
    );

    modport master (
        output s_axis_real_tdata, s_axis_imag_tdata,
        output s_axis_real_tvalid, s_axis_imag_tvalid,
        input  s_axis_real_tready, s_axis_imag_tready,
        output s_axis_real_tlast, s_axis_imag_tlast,
        input  m_axis_real_tdata, m_axis_imag_tdata,
        input  m_axis_real_tkeep, m_axis_imag_tkeep,
        input  m_axis_real_tvalid, m_axis_imag_tvalid,
        input  m_axis_real_tlast, m_axis_imag_tlast,
        output m_axis_real_tready, m_axis_imag_tready
    );
endinterface

// File: rtl/axis_combiner.sv
// Complex multi-channel AXI-Stream combiner.
// Sums sample i of every channel (real and imag separately) at full
// precision, applies an arithmetic right shift, and reduces the result to
// the output sample width. Two register stages: sum, then output.
// Optional feature: define AXIS_COMBINER_SAT_EN to saturate out-of-range
// results instead of wrapping them to the low MSAMPLE_WIDTH bits.
module axis_combiner #(
    parameter int NUM_CH        = 4,
    parameter int SDATA_WIDTH   = 128,
    parameter int SSAMPLE_WIDTH = 16,
    parameter int MSAMPLE_WIDTH = 16,
    parameter int SHIFT         = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    axis_combiner_if.slave       bus,
    output logic                 tlast_err,
    output logic [31:0]          frame_count
);
    localparam int SAMPLES     = SDATA_WIDTH / SSAMPLE_WIDTH;
    localparam int MDATA_WIDTH = SAMPLES * MSAMPLE_WIDTH;
    localparam int SUM_W       = SSAMPLE_WIDTH + $clog2(NUM_CH);
    // Wide enough to hold any sum and any output sample with sign headroom
    localparam int EXT_W       = SUM_W + MSAMPLE_WIDTH;

    // Shift a full-precision sum and fit it to the output sample width
    function automatic logic [MSAMPLE_WIDTH-1:0] reduce_fn(input logic [SUM_W-1:0] sum);
        logic signed [EXT_W-1:0] ext_v;
`ifdef AXIS_COMBINER_SAT_EN
        logic signed [EXT_W-1:0] one_v;
        logic signed [EXT_W-1:0] max_v;
        logic signed [EXT_W-1:0] min_v;
`endif
        ext_v = EXT_W'($signed(sum)) >>> SHIFT;
`ifdef AXIS_COMBINER_SAT_EN
        one_v = EXT_W'(1'b1);
        max_v = (one_v <<< (MSAMPLE_WIDTH - 1)) - one_v;
        min_v = -(one_v <<< (MSAMPLE_WIDTH - 1));
        if (ext_v > max_v) begin
            return max_v[MSAMPLE_WIDTH-1:0];
        end else if (ext_v < min_v) begin
            return min_v[MSAMPLE_WIDTH-1:0];
        end else begin
            return ext_v[MSAMPLE_WIDTH-1:0];
        end
`else
        return ext_v[MSAMPLE_WIDTH-1:0];
`endif
    endfunction

    logic                             all_valid_s;
    logic                             advance_s;
    logic                             accept_s;
    logic                             tlast_mismatch_s;
    logic                             beat_done_s;
    logic [SAMPLES-1:0][SUM_W-1:0]    real_sum_s;
    logic [SAMPLES-1:0][SUM_W-1:0]    imag_sum_s;
    logic [MDATA_WIDTH-1:0]           real_next_s;
    logic [MDATA_WIDTH-1:0]           imag_next_s;

    logic [SAMPLES-1:0][SUM_W-1:0]    real_sum_r;
    logic [SAMPLES-1:0][SUM_W-1:0]    imag_sum_r;
    logic                             sum_valid_r;
    logic                             sum_tlast_r;
    logic [MDATA_WIDTH-1:0]           out_real_r;
    logic [MDATA_WIDTH-1:0]           out_imag_r;
    logic                             out_valid_r;
    logic                             out_tlast_r;
    logic                             tlast_err_r;
    logic [31:0]                      frame_count_r;

    // Handshake: a beat is taken only when every stream is valid and the pipe moves
    always_comb begin
        all_valid_s      = (&bus.s_axis_real_tvalid) & (&bus.s_axis_imag_tvalid);
        advance_s        = ~out_valid_r | (bus.m_axis_real_tready & bus.m_axis_imag_tready);
        accept_s         = ~reset & all_valid_s & advance_s;
        tlast_mismatch_s = ~((&{bus.s_axis_real_tlast, bus.s_axis_imag_tlast}) |
                             ~(|{bus.s_axis_real_tlast, bus.s_axis_imag_tlast}));
        beat_done_s      = out_valid_r & bus.m_axis_real_tready & bus.m_axis_imag_tready;
    end

    // Full-precision per-sample sums across all channels
    always_comb begin
        real_sum_s = '0;
        imag_sum_s = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                real_sum_s[i] = real_sum_s[i] + SUM_W'($signed(
                    bus.s_axis_real_tdata[k*SDATA_WIDTH + i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]));
                imag_sum_s[i] = imag_sum_s[i] + SUM_W'($signed(
                    bus.s_axis_imag_tdata[k*SDATA_WIDTH + i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]));
            end
        end
    end

    // Shift and width reduction of the registered sums
    always_comb begin
        real_next_s = '0;
        imag_next_s = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            real_next_s[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] = reduce_fn(real_sum_r[i]);
            imag_next_s[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] = reduce_fn(imag_sum_r[i]);
        end
    end

    // Sum stage: loads on acceptance, empties when the pipe moves without a new beat
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            real_sum_r  <= '0;
            imag_sum_r  <= '0;
            sum_valid_r <= 1'b0;
            sum_tlast_r <= 1'b0;
        end else if (advance_s) begin
            sum_valid_r <= accept_s;
            if (accept_s) begin
                real_sum_r  <= real_sum_s;
                imag_sum_r  <= imag_sum_s;
                sum_tlast_r <= bus.s_axis_real_tlast[0];
            end
        end
    end

    // Output stage: takes the sum stage whenever the pipe moves
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_real_r  <= '0;
            out_imag_r  <= '0;
            out_valid_r <= 1'b0;
            out_tlast_r <= 1'b0;
        end else if (advance_s) begin
            out_real_r  <= real_next_s;
            out_imag_r  <= imag_next_s;
            out_valid_r <= sum_valid_r;
            out_tlast_r <= sum_tlast_r;
        end
    end

    // Sticky flag for channels disagreeing on frame end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tlast_err_r <= 1'b0;
        end else if (accept_s && tlast_mismatch_s) begin
            tlast_err_r <= 1'b1;
        end
    end

    // Completed-frame counter, wraps naturally at 32 bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count_r <= 32'd0;
        end else if (beat_done_s && out_tlast_r) begin
            frame_count_r <= frame_count_r + 32'd1;
        end
    end

    assign bus.s_axis_real_tready = {NUM_CH{accept_s}};
    assign bus.s_axis_imag_tready = {NUM_CH{accept_s}};
    assign bus.m_axis_real_tdata  = out_real_r;
    assign bus.m_axis_imag_tdata  = out_imag_r;
    assign bus.m_axis_real_tkeep  = {(MDATA_WIDTH/8){out_valid_r}};
    assign bus.m_axis_imag_tkeep  = {(MDATA_WIDTH/8){out_valid_r}};
    assign bus.m_axis_real_tvalid = out_valid_r;
    assign bus.m_axis_imag_tvalid = out_valid_r;
    assign bus.m_axis_real_tlast  = out_tlast_r;
    assign bus.m_axis_imag_tlast  = out_tlast_r;
    assign tlast_err              = tlast_err_r;
    assign frame_count            = frame_count_r;
endmodule

// File: tb/tb_axis_combiner.sv
// Directed bench for axis_combiner with default parameters (4 channels,
// 8 samples of 16 bits per beat, SHIFT=0).
module tb_axis_combiner;
    logic        clock;
    logic        reset;
    logic        tlast_err;
    logic [31:0] frame_count;
    int          total_cnt;
    int          pass_cnt;
    int          fail_cnt;
    logic [127:0] exp_r;
    logic [127:0] exp_i;

    axis_combiner_if #(.NUM_CH(4), .SDATA_WIDTH(128), .MDATA_WIDTH(128)) bus ();

    axis_combiner dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .tlast_err   (tlast_err),
        .frame_count (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Every channel and sample gets the same real/imag value
    task automatic drive(input logic [15:0] rv, input logic [15:0] iv,
                         input logic [3:0] rl, input logic [3:0] il);
        bus.s_axis_real_tdata  = {32{rv}};
        bus.s_axis_imag_tdata  = {32{iv}};
        bus.s_axis_real_tvalid = 4'hF;
        bus.s_axis_imag_tvalid = 4'hF;
        bus.s_axis_real_tlast  = rl;
        bus.s_axis_imag_tlast  = il;
    endtask

    task automatic idle();
        bus.s_axis_real_tvalid = 4'h0;
        bus.s_axis_imag_tvalid = 4'h0;
        bus.s_axis_real_tlast  = 4'h0;
        bus.s_axis_imag_tlast  = 4'h0;
    endtask

    task automatic mready(input logic r, input logic i);
        bus.m_axis_real_tready = r;
        bus.m_axis_imag_tready = i;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        reset     = 1'b1;
        bus.s_axis_real_tdata = '0;
        bus.s_axis_imag_tdata = '0;
        idle();
        mready(1'b1, 1'b1);

        // Reset state, with every input valid so tready must still be held low
        repeat (3) step();
        drive(16'h0100, 16'hFF00, 4'h0, 4'h0);
        #1;
        check("rst_tready", {bus.s_axis_real_tready, bus.s_axis_imag_tready}, 128'h0);
        check("rst_mvalid", {bus.m_axis_real_tvalid, bus.m_axis_imag_tvalid}, 128'h0);
        check("rst_mtlast", {bus.m_axis_real_tlast, bus.m_axis_imag_tlast}, 128'h0);
        check("rst_tdata", bus.m_axis_real_tdata | bus.m_axis_imag_tdata, 128'h0);
        check("rst_tkeep", {bus.m_axis_real_tkeep, bus.m_axis_imag_tkeep}, 128'h0);
        check("rst_err_cnt", {tlast_err, frame_count}, 128'h0);

        // Basic sum: 4 x 0x0100 = 0x0400, 4 x 0xFF00 = 0xFC00, latency 2
        step();
        reset = 1'b0;
        #1;
        check("basic_tready", {bus.s_axis_real_tready, bus.s_axis_imag_tready}, 128'hFF);
        step();
        idle();
        check("basic_lat1", bus.m_axis_real_tvalid, 128'h0);
        step();
        check("basic_valid", {bus.m_axis_real_tvalid, bus.m_axis_imag_tvalid}, 128'h3);
        check("basic_real", bus.m_axis_real_tdata, {8{16'h0400}});
        check("basic_imag", bus.m_axis_imag_tdata, {8{16'hFC00}});
        check("basic_tkeep", {bus.m_axis_real_tkeep, bus.m_axis_imag_tkeep}, {32'hFFFF_FFFF});
        step();
        check("basic_drain", bus.m_axis_real_tvalid, 128'h0);

        // Overflow: +0x7000 x4 and -0x7000 x4
        drive(16'h7000, 16'h9000, 4'h0, 4'h0);
        step();
        idle();
        step();
`ifdef AXIS_COMBINER_SAT_EN
        exp_r = {8{16'h7FFF}};
        exp_i = {8{16'h8000}};
`else
        exp_r = {8{16'hC000}};
        exp_i = {8{16'h4000}};
`endif
        check("ovf_real", bus.m_axis_real_tdata, exp_r);
        check("ovf_imag", bus.m_axis_imag_tdata, exp_i);
        step();

        // Channel 2 real tvalid low: nothing accepted, nothing produced
        drive(16'h0000, 16'h0000, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                bus.s_axis_real_tdata[k*128 + i*16 +: 16] = 16'(k*16 + i);
                bus.s_axis_imag_tdata[k*128 + i*16 +: 16] = 16'(-(k*16 + i));
            end
        end
        bus.s_axis_real_tvalid = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("gap_tready", {bus.s_axis_real_tready, bus.s_axis_imag_tready}, 128'h0);
            check("gap_mvalid", bus.m_axis_real_tvalid, 128'h0);
            step();
        end
        bus.s_axis_real_tvalid = 4'hF;
        #1;
        check("gap_accept", {bus.s_axis_real_tready, bus.s_axis_imag_tready}, 128'hFF);
        step();
        idle();
        step();
        for (int i = 0; i < 8; i++) begin
            exp_r[i*16 +: 16] = 16'(96 + 4*i);
            exp_i[i*16 +: 16] = 16'(-(96 + 4*i));
        end
        check("lanes_real", bus.m_axis_real_tdata, exp_r);
        check("lanes_imag", bus.m_axis_imag_tdata, exp_i);
        step();

        // Backpressure with two beats in flight: A=0x10, B=0x20, C=0x30 per sample
        mready(1'b0, 1'b0);
        drive(16'h0010, 16'h0000, 4'h0, 4'h0);
        #1;
        check("bp_accA", bus.s_axis_real_tready, 128'hF);
        step();
        drive(16'h0020, 16'h0000, 4'h0, 4'h0);
        #1;
        check("bp_accB", bus.s_axis_real_tready, 128'hF);
        step();
        drive(16'h0030, 16'h0000, 4'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            mready(c == 0, 1'b0);
            #1;
            check("bp_stall_tready", {bus.s_axis_real_tready, bus.s_axis_imag_tready}, 128'h0);
            check("bp_hold", {bus.m_axis_real_tvalid, bus.m_axis_real_tdata}, {1'b1, {8{16'h0040}}});
            step();
        end
        mready(1'b1, 1'b1);
        #1;
        check("bp_rel_tready", bus.s_axis_real_tready, 128'hF);
        check("bp_outA", {bus.m_axis_real_tvalid, bus.m_axis_real_tdata}, {1'b1, {8{16'h0040}}});
        step();
        idle();
        check("bp_outB", {bus.m_axis_real_tvalid, bus.m_axis_real_tdata}, {1'b1, {8{16'h0080}}});
        step();
        check("bp_outC", {bus.m_axis_real_tvalid, bus.m_axis_real_tdata}, {1'b1, {8{16'h00C0}}});
        step();
        check("bp_empty", bus.m_axis_real_tvalid, 128'h0);

        // Misaligned tlast: only channel 1 real flags frame end
        drive(16'h0005, 16'h0005, 4'b0010, 4'b0000);
        step();
        idle();
        check("err_set", tlast_err, 128'h1);
        step();
        check("err_out_tlast", {bus.m_axis_real_tvalid, bus.m_axis_real_tlast}, 128'h2);
        step();
        check("err_no_frame", frame_count, 128'h0);

        // Aligned 4-beat frame streamed back to back (beat b sums to 4*(b+1))
        for (int b = 0; b < 6; b++) begin
            if (b < 4) begin
                drive(16'(b + 1), 16'(-(b + 1)), (b == 3) ? 4'hF : 4'h0, (b == 3) ? 4'hF : 4'h0);
            end else begin
                idle();
            end
            #1;
            if (b >= 2) begin
                check("frame_beat", {bus.m_axis_real_tvalid, bus.m_axis_real_tlast,
                                     bus.m_axis_imag_tlast, bus.m_axis_real_tdata},
                      {1'b1, b == 5, b == 5, {8{16'(4*(b - 1))}}});
            end
            step();
        end
        check("frame_count1", frame_count, 128'h1);
        check("err_sticky", tlast_err, 128'h1);

        // Reset with two beats in flight
        mready(1'b0, 1'b0);
        drive(16'h0011, 16'h0011, 4'h0, 4'h0);
        step();
        drive(16'h0022, 16'h0022, 4'h0, 4'h0);
        step();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_mvalid", {bus.m_axis_real_tvalid, bus.m_axis_imag_tvalid}, 128'h0);
        check("mid_rst_state", {bus.s_axis_real_tready, tlast_err, frame_count}, 128'h0);
        step();
        reset = 1'b0;
        mready(1'b1, 1'b1);
        drive(16'h0001, 16'hFFFF, 4'hF, 4'hF);
        #1;
        check("post_rst_tready", {bus.s_axis_real_tready, bus.s_axis_imag_tready}, 128'hFF);
        step();
        idle();
        check("post_rst_bubble", bus.m_axis_real_tvalid, 128'h0);
        step();
        check("post_rst_data", {bus.m_axis_real_tvalid, bus.m_axis_real_tlast,
                                bus.m_axis_real_tdata, bus.m_axis_imag_tdata[15:0]},
              {1'b1, 1'b1, {8{16'h0004}}, 16'hFFFC});
        check("post_rst_err", tlast_err, 128'h0);
        step();
        check("post_rst_frame", {bus.m_axis_real_tvalid, frame_count}, 128'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
